// File: rtl/alu_pkg.sv
// Shared op encodings and flag-vector layout for the pipelined ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_W = 4;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational op/flag datapath between the operand and result stages.
// Macro ALU_SAT_EN: ADD/SUB clamp on carry/borrow instead of wrapping.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     shr;
    logic [SHAMT_W-1:0] n;
    logic               sa;
    logic               sb;
    logic               carry;
    logic               ovf;
    logic [WIDTH-1:0]   res;

    // Shifts run one bit wider so the last bit shifted out lands in a fixed slot.
    always_comb begin
        n    = b[SHAMT_W-1:0];
        sa   = a[WIDTH-1];
        sb   = b[WIDTH-1];
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        shl  = {1'b0, a} << n;
        shr  = {a, 1'b0} >> n;
    end

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (sa == sb) && (sum[WIDTH-1] != sa);
`ifdef ALU_SAT_EN
                if (carry) res = '1;
`endif
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (sa != sb) && (diff[WIDTH-1] != sa);
`ifdef ALU_SAT_EN
                if (carry) res = '0;
`endif
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOT: res = ~a;
            OP_SHL: begin
                res   = shl[WIDTH-1:0];
                carry = shl[WIDTH];
            end
            OP_SHR: begin
                res   = shr[WIDTH:1];
                carry = shr[0];
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        result         = res;
        flags          = '0;
        flags[FLAG_C]  = carry;
        flags[FLAG_Z]  = (res == '0);
        flags[FLAG_N]  = res[WIDTH-1];
        flags[FLAG_V]  = ovf;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU with a sticky signed-overflow status.
// Macro ALU_SAT_EN (see alu_core) selects saturating ADD/SUB.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s2_adv;
    logic [WIDTH-1:0] core_result;
    flags_t           core_flags;

    // Both stages shift together whenever the result slot is free or draining.
    always_comb begin
        s2_adv   = !out_valid || out_ready;
        in_ready = !s1_valid || s2_adv;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op;
            end
        end
    end

    alu_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_result),
        .flags  (core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result    <= core_result;
                carry_out <= core_flags[FLAG_C];
                zero      <= core_flags[FLAG_Z];
                neg       <= core_flags[FLAG_N];
                ovf       <= core_flags[FLAG_V];
            end
        end
    end

    // A departing overflow beat beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboarded bench for alu_pipe at WIDTH=8: directed vector table, random streams, stall, reset, sticky clear.
module tb_alu_pipe;

    localparam int unsigned W = 8;

    typedef struct {
        logic [7:0] result;
        logic       carry;
        logic       zero;
        logic       neg;
        logic       ovf;
        int         acc_cyc;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       v;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = 3'b000;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         clr_sticky = 1'b0;
    logic         ovf_sticky;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   fire_cnt = 0;
    int   last_fire_cyc = -10;
    int   run_len = 0;
    bit   lat_chk = 1'b0;
    bit   sticky_m = 1'b0;
    exp_t cur_exp;
    exp_t sb_q[$];
    vec_t vecs[16];

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry_out  (carry_out),
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [7:0] r, input logic c, input logic v);
        exp_t e;
        e.result  = r;
        e.carry   = c;
        e.zero    = (r == 8'h00);
        e.neg     = r[7];
        e.ovf     = v;
        e.acc_cyc = 0;
        return e;
    endfunction

    function automatic logic [7:0] sat_adj(input logic [2:0] o, input logic [7:0] r, input logic c);
        logic [7:0] x;
        x = r;
`ifdef ALU_SAT_EN
        if (o == 3'b000 && c) x = 8'hFF;
        if (o == 3'b001 && c) x = 8'h00;
`endif
        return x;
    endfunction

    // Integer reference model of one ALU operation.
    function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        int         ai;
        int         bi;
        int         s;
        int         n;
        logic [7:0] r;
        logic       c;
        logic       v;
        ai = int'(x);
        bi = int'(y);
        n  = bi % 8;
        r  = 8'h00;
        c  = 1'b0;
        v  = 1'b0;
        case (o)
            3'b000: begin
                s = ai + bi;
                r = 8'(s % 256);
                c = (s > 255);
                v = (x[7] == y[7]) && (r[7] != x[7]);
            end
            3'b001: begin
                s = ai - bi + 256;
                r = 8'(s % 256);
                c = (ai < bi);
                v = (x[7] != y[7]) && (r[7] != x[7]);
            end
            3'b010: r = x & y;
            3'b011: r = x | y;
            3'b100: r = x ^ y;
            3'b101: r = ~x;
            3'b110: begin
                r = 8'((ai * (1 << n)) % 256);
                c = (n != 0) && (((ai >> (8 - n)) % 2) == 1);
            end
            default: begin
                r = 8'(ai >> n);
                c = (n != 0) && (((ai >> (n - 1)) % 2) == 1);
            end
        endcase
        return mk_exp(sat_adj(o, r, c), c, v);
    endfunction

    // Monitor: pushes on accept, checks the head entry whenever out_valid, pops on transfer.
    always @(negedge clk) begin
        bit   fire;
        exp_t h;
        if (rst) begin
            sticky_m = 1'b0;
        end else begin
            cyc++;
            check("ovf_sticky", 32'(ovf_sticky), 32'(sticky_m));
            fire = out_valid && out_ready;
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                    fire = 1'b0;
                end else begin
                    h = sb_q[0];
                    check("result", 32'(result), 32'(h.result));
                    check("flags{c,z,n,v}", 32'({carry_out, zero, neg, ovf}),
                          32'({h.carry, h.zero, h.neg, h.ovf}));
                    if (fire) begin
                        if (lat_chk) check("latency", 32'(cyc - h.acc_cyc), 32'd2);
                        if (h.ovf) sticky_m = 1'b1;
                        else if (clr_sticky) sticky_m = 1'b0;
                        void'(sb_q.pop_front());
                        fire_cnt++;
                        run_len = (last_fire_cyc == cyc - 1) ? run_len + 1 : 1;
                        last_fire_cyc = cyc;
                    end
                end
            end
            if (!fire && clr_sticky) sticky_m = 1'b0;
            if (in_valid && in_ready) begin
                h = cur_exp;
                h.acc_cyc = cyc;
                sb_q.push_back(h);
                acc_cnt++;
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input exp_t e);
        bit ok;
        bit acc;
        cur_exp  = e;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 64; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_fire(input int target);
        for (int k = 0; k < 64; k++) begin
            if (fire_cnt >= target) break;
            @(posedge clk);
        end
        check("fire_timeout", 32'(fire_cnt >= target), 32'd1);
    endtask

    initial begin
        logic [2:0] ro;
        logic [7:0] ra;
        logic [7:0] rb;
        int         f0;
        int         a0;

        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 8'h04, 8'h08, 8'hFC, 1'b1, 1'b0};
        vecs[2]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{3'b110, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0};
        vecs[4]  = '{3'b111, 8'h81, 8'h0A, 8'h20, 1'b0, 1'b0};
        vecs[5]  = '{3'b110, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0};
        vecs[6]  = '{3'b111, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0};
        vecs[7]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[8]  = '{3'b011, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0};
        vecs[9]  = '{3'b100, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{3'b101, 8'h0F, 8'hAA, 8'hF0, 1'b0, 1'b0};
        vecs[11] = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[12] = '{3'b111, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0};
        vecs[13] = '{3'b110, 8'h03, 8'h07, 8'h80, 1'b1, 1'b0};
        vecs[14] = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[15] = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0};

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({carry_out, zero, neg, ovf}), 32'd0);
        check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);

        // Directed vector table, free-flowing
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b,
                 mk_exp(sat_adj(vecs[i].op, vecs[i].res, vecs[i].c), vecs[i].c, vecs[i].v));
        end
        drain();
        repeat (2) @(posedge clk);
        #1;

        // 16 random back-to-back beats
        f0 = fire_cnt;
        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(ro, ra, rb, model(ro, ra, rb));
        end
        drain();
        check("random_fire_count", 32'(fire_cnt - f0), 32'd16);
        check("random_consecutive_run", 32'(run_len), 32'd16);
        lat_chk = 1'b0;

        // Stall with in_valid held: only two beats fit
        out_ready = 1'b0;
        f0 = fire_cnt;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    ro = 3'($urandom_range(0, 7));
                    ra = 8'($urandom_range(0, 255));
                    rb = 8'($urandom_range(0, 255));
                    send(ro, ra, rb, model(ro, ra, rb));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                check("stall_accepts", 32'(acc_cnt - a0), 32'd2);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_fire_count", 32'(fire_cnt - f0), 32'd4);
        check("stall_accept_count", 32'(acc_cnt - a0), 32'd4);

        // Reset with two beats in flight
        check("sticky_before_rst", 32'(ovf_sticky), 32'd1);
        out_ready = 1'b0;
        send(3'b000, 8'h7F, 8'h01, model(3'b000, 8'h7F, 8'h01));
        send(3'b010, 8'hAA, 8'h0F, model(3'b010, 8'hAA, 8'h0F));
        check("inflight_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_sticky", 32'(ovf_sticky), 32'd0);
        check("async_rst_result", 32'(result), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_replay_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // clr_sticky coinciding with an overflow beat: the set wins
        clr_sticky = 1'b1;
        f0 = fire_cnt;
        send(3'b000, 8'h7F, 8'h01, model(3'b000, 8'h7F, 8'h01));
        wait_fire(f0 + 1);
        @(negedge clk);
        check("clr_vs_set_sticky", 32'(ovf_sticky), 32'd1);
        @(negedge clk);
        check("clr_sticky_clears", 32'(ovf_sticky), 32'd0);
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
